// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the accumulating calculator.
//   op_t     - operation encoding applied on each request pulse
//   HEX_SEG  - active-low 7-segment patterns for hex digits 0..F,
//              bit 0 = segment a ... bit 6 = segment g
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_CLEAR = 2'b11
    } op_t;

    // Element 0 is the rightmost entry of the pattern below.
    localparam logic [15:0][6:0] HEX_SEG = '{
        7'h0E, // F
        7'h06, // E
        7'h21, // d
        7'h46, // C
        7'h03, // b
        7'h08, // A
        7'h10, // 9
        7'h00, // 8
        7'h78, // 7
        7'h02, // 6
        7'h12, // 5
        7'h19, // 4
        7'h30, // 3
        7'h24, // 2
        7'h79, // 1
        7'h40  // 0
    };

endpackage

// File: rtl/hex7seg_dec.sv
// hex7seg_dec: combinational hex nibble to active-low 7-segment decoder.
// Ports:
//   nibble  in   4  hex value 0..F
//   seg     out  7  active-low segments, seg[0]=a ... seg[6]=g
module hex7seg_dec
    import calc_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_SEG[nibble];
    end

endmodule

// File: rtl/calc_accum_display.sv
// calc_accum_display: accumulating calculator core with multiplexed hex display.
// The operand is the population count of in_bits; add/sub/load/clear are applied
// once per debounced rising edge of add_req. The accumulator drives a
// time-multiplexed DIGITS-digit hex display.
// Build option: define CALC_SATURATE_EN to clamp add/sub results at the range
// limits instead of wrapping (ovf is set either way).
// Ports:
//   clk      in   1       system clock, rising edge
//   reset    in   1       asynchronous active-high reset
//   in_bits  in   N_IN    operand switches (operand = popcount)
//   op       in   2       00 add, 01 sub, 10 load, 11 clear
//   add_req  in   1       asynchronous request button level
//   acc      out  ACC_W   accumulator value
//   ovf      out  1       sticky overflow/underflow flag
//   seg      out  7       active-low segments of the lit digit
//   dig_en   out  DIGITS  active-low one-hot digit enable
module calc_accum_display
    import calc_pkg::*;
#(
    parameter int unsigned N_IN     = 4,
    parameter int unsigned ACC_W    = 8,
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_IN-1:0]   in_bits,
    input  logic [1:0]        op,
    input  logic              add_req,
    output logic [ACC_W-1:0]  acc,
    output logic              ovf,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] dig_en
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PAD_W = (DIGITS * 4 > ACC_W) ? DIGITS * 4 : ACC_W;

    // ---------------- request synchroniser and edge detect ----------------
    // All three flops reset high so a button held through reset never fires.
    logic sync1_q, sync2_q, hist_q;
    logic req_pulse;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
        end else begin
            sync1_q <= add_req;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign req_pulse = sync2_q & ~hist_q;

    // ---------------- operand and ALU ----------------
    logic [ACC_W:0]   operand;
    logic [ACC_W:0]   sum_w;
    logic [ACC_W:0]   diff_w;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        operand = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            operand = operand + {{ACC_W{1'b0}}, in_bits[i]};
        end
    end

    // The extra top bit is the carry on add and the borrow on sub.
    assign sum_w  = {1'b0, acc_q} + operand;
    assign diff_w = {1'b0, acc_q} - operand;

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (req_pulse) begin
            case (op_t'(op))
                OP_ADD: begin
                    acc_d = sum_w[ACC_W-1:0];
                    if (sum_w[ACC_W]) begin
                        ovf_d = 1'b1;
`ifdef CALC_SATURATE_EN
                        acc_d = '1;
`endif
                    end
                end
                OP_SUB: begin
                    acc_d = diff_w[ACC_W-1:0];
                    if (diff_w[ACC_W]) begin
                        ovf_d = 1'b1;
`ifdef CALC_SATURATE_EN
                        acc_d = '0;
`endif
                    end
                end
                OP_LOAD: begin
                    acc_d = operand[ACC_W-1:0];
                end
                OP_CLEAR: begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                end
                default: begin
                    acc_d = acc_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc = acc_q;
    assign ovf = ovf_q;

    // ---------------- display scan ----------------
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [PAD_W-1:0]  acc_pad;
    logic [3:0]        nibble;
    logic [6:0]        seg_dec;
    logic [6:0]        seg_q;
    logic [DIGITS-1:0] dig_en_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_q <= '0;
            idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Nibbles above ACC_W read as zero via the zero-extended copy.
    assign acc_pad = PAD_W'(acc_q);
    assign nibble  = acc_pad[{idx_q, 2'b00} +: 4];

    hex7seg_dec u_dec (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q    <= 7'b1000000;
            dig_en_q <= ~DIGITS'(1);
        end else begin
            seg_q    <= seg_dec;
            dig_en_q <= ~(DIGITS'(1) << idx_q);
        end
    end

    assign seg    = seg_q;
    assign dig_en = dig_en_q;

endmodule

// File: tb/tb_calc_accum_display.sv
// Self-checking bench for calc_accum_display (N_IN=4, ACC_W=8, DIGITS=2,
// SCAN_DIV=4). Expected values are hand-computed; the saturating variants
// are selected with CALC_SATURATE_EN.
module tb_calc_accum_display;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in_bits;
    logic [1:0] op;
    logic       add_req;
    logic [7:0] acc;
    logic       ovf;
    logic [6:0] seg;
    logic [1:0] dig_en;

    int checks = 0;
    int errors = 0;

    calc_accum_display #(
        .N_IN     (4),
        .ACC_W    (8),
        .DIGITS   (2),
        .SCAN_DIV (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_bits (in_bits),
        .op      (op),
        .add_req (add_req),
        .acc     (acc),
        .ovf     (ovf),
        .seg     (seg),
        .dig_en  (dig_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One full request: high for `hold` cycles, then low for 3 cycles.
    task automatic do_op(input logic [1:0] o, input logic [3:0] b, input int hold);
        op      = o;
        in_bits = b;
        add_req = 1'b1;
        step(hold);
        add_req = 1'b0;
        step(3);
    endtask

    logic [1:0] cur;
    logic [1:0] exp_en;
    bit         found;

    initial begin
        reset   = 1'b1;
        add_req = 1'b1;
        op      = 2'b00;
        in_bits = 4'b1111;
        step(3);
        check("rst_acc", acc, 0);
        check("rst_ovf", ovf, 0);
        check("rst_seg", seg, 7'b1000000);
        check("rst_dig", dig_en, 2'b10);

        // Button held through reset release must not fire.
        reset = 1'b0;
        step(1);
        check("rel_dig", dig_en, 2'b10);
        check("rel_seg", seg, 7'b1000000);
        step(10);
        check("held_acc", acc, 0);
        check("held_ovf", ovf, 0);
        add_req = 1'b0;
        step(3);

        // Latency: acc changes after the third edge following the rise.
        op      = 2'b00;
        in_bits = 4'b1011;
        add_req = 1'b1;
        step(2);
        check("lat_k1", acc, 0);
        step(1);
        check("lat_k2", acc, 3);
        add_req = 1'b0;
        step(3);
        do_op(2'b00, 4'b1011, 3);
        check("add2", acc, 6);
        do_op(2'b00, 4'b1011, 100);
        check("hold100", acc, 9);
        check("hold100_ovf", ovf, 0);

        // Underflow from zero.
        do_op(2'b11, 4'b0000, 3);
        check("clr_acc", acc, 0);
        do_op(2'b01, 4'b0001, 3);
`ifdef CALC_SATURATE_EN
        check("sub_uf", acc, 8'h00);
`else
        check("sub_uf", acc, 8'hFF);
`endif
        check("sub_uf_ovf", ovf, 1);

        // Build acc = 0xFE from zero: 63 x 4 + 2.
        do_op(2'b11, 4'b0000, 3);
        check("clr_ovf", ovf, 0);
        for (int i = 0; i < 63; i++) do_op(2'b00, 4'b1111, 3);
        do_op(2'b00, 4'b0011, 3);
        check("fe_acc", acc, 8'hFE);
        check("fe_ovf", ovf, 0);
        do_op(2'b00, 4'b0111, 3);
`ifdef CALC_SATURATE_EN
        check("add_of", acc, 8'hFF);
`else
        check("add_of", acc, 8'h01);
`endif
        check("add_of_ovf", ovf, 1);

        // Load keeps the sticky flag.
        do_op(2'b10, 4'b0110, 3);
        check("load_acc", acc, 2);
        check("load_ovf", ovf, 1);
        do_op(2'b11, 4'b0000, 3);
        check("clr2_acc", acc, 0);
        check("clr2_ovf", ovf, 0);

        // Build acc = 0x3A: 14 x 4 + 2.
        for (int i = 0; i < 14; i++) do_op(2'b00, 4'b1111, 3);
        do_op(2'b00, 4'b0011, 3);
        check("acc_3a", acc, 8'h3A);

        // Align to a digit change, then follow two full periods.
        cur   = dig_en;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1);
            if (dig_en !== cur) found = 1'b1;
        end
        check("scan_align", found, 1);
        cur = dig_en;
        for (int i = 0; i < 8; i++) begin
            exp_en = (i < 4) ? cur : ~cur;
            check("scan_dig", dig_en, exp_en);
            check("scan_seg", seg, (exp_en == 2'b10) ? 7'b0001000 : 7'b0110000);
            step(1);
        end

        // Reset while digit 1 is lit.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (dig_en === 2'b01) found = 1'b1;
            else step(1);
        end
        check("mid_align", found, 1);
        step(1);
        reset = 1'b1;
        step(1);
        check("mid_rst_dig", dig_en, 2'b10);
        check("mid_rst_seg", seg, 7'b1000000);
        check("mid_rst_acc", acc, 0);
        reset = 1'b0;
        step(4);
        check("restart_hold", dig_en, 2'b10);
        step(1);
        check("restart_next", dig_en, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
